ofmap_pack_fifo: RTL and testbench
==================================

# ofmap_pack_fifo

Byte-to-word packing FIFO on the output side of the CONV unit. It collects 8-bit results from the PE array into little-endian 32-bit words and buffers up to DEPTH complete words. A GLB write-back engine drains it one 32-bit word at a time, with a byte strobe per word. It complements the ifmap FIFO's 32-bit-in / 8-bit-out path with an 8-bit-in / 32-bit-out path.

## Interface
- DEPTH, 4, number of 32-bit word entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- push_en  in  1  push one byte
- push_data  in  8  byte to push
- flush  in  1  commit the partially packed word with a partial strobe
- full  out  1  word storage holds DEPTH words; pushes and flushes are ignored
- pend_bytes  out  2  bytes currently held in the pack register (0..3)
- pop_en  in  1  pop one word
- pop_data  out  32  popped word, registered
- pop_strb  out  4  popped byte strobe, registered; bit i = lane i valid
- empty  out  1  no complete word stored

## Operation
- Internal state:
  - pack register: lanes 0..2, 8 bits each
  - byte_idx: 2 bits, next lane to fill
  - word memory mem[DEPTH] × 32 bits and strb[DEPTH] × 4 bits
  - wr_ptr, rd_ptr: log2(DEPTH) bits each, natural wrap
  - count: log2(DEPTH)+1 bits
- full = (count == DEPTH); empty = (count == 0); pend_bytes = byte_idx. All are combinational from registers.
- Push is accepted when push_en && !full. Lane order is little-endian: lane0 = bits[7:0], lane3 = bits[31:24].
- Accepted push with byte_idx < 3 and no flush:
  - pack[byte_idx] <= push_data
  - byte_idx increments
- Accepted push with byte_idx == 3 (commit):
  - mem[wr_ptr] <= {push_data, pack[2], pack[1], pack[0]}; strb <= 4'b1111
  - wr_ptr increments; byte_idx <= 0
- Flush is accepted when flush && !full. Let n = byte_idx + (push accepted ? 1 : 0).
  - n == 0: no-op.
  - n == 4: identical to a full-word commit.
  - 1 ≤ n ≤ 3: commit lanes 0..n-1, including the same-cycle byte at lane byte_idx. Unused lanes are written as 0. strb = (1<<n)-1. wr_ptr increments; byte_idx <= 0.
- Pop is accepted when pop_en && !empty:
  - pop_data <= mem[rd_ptr]; pop_strb <= strb[rd_ptr]
  - rd_ptr increments
- On cycles without an accepted pop, pop_data and pop_strb hold their values.
- count update:
  - +1 on commit only
  - −1 on pop only
  - unchanged when a commit and a pop occur in the same cycle
- pop_en while empty: no change. push_en or flush while full: dropped, and pack state is unchanged.
- Full is state-based: a pop in the same cycle does not let a push be accepted while full == 1.

## Timing
- Reset (asynchronous, any cycle, including mid-word or mid-drain) clears:
  - pointers, count, byte_idx, pack register
  - pop_data = 0, pop_strb = 0
  - Resulting outputs: empty = 1, full = 0, pend_bytes = 0
  - Partial bytes and stored words are discarded; mem contents need no reset.
- A committed word is visible (empty = 0) in the cycle after the commit edge.
- Pop latency is 1 cycle: pop_data/pop_strb are valid in the cycle after the pop_en edge.
- full drops in the cycle after an accepted pop from a full FIFO.
- Sustained throughput: one byte push per cycle and one word pop per 4 cycles, with no stall once DEPTH ≥ 2.
- Pointers wrap from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset: assert rst_n = 0 asynchronously mid-cycle. Required: pop_data = 0, pop_strb = 0, empty = 1, full = 0, pend_bytes = 0 immediately.
- Basic pack: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: pend_bytes goes 1, 2, 3, 0; empty = 0 after the 4th edge. Then pop. Required next cycle: pop_data = 0x44332211, pop_strb = 4'b1111, empty = 1.
- Flush:
  - Push 0xAA, 0xBB, then flush. Required on pop: 0x0000BBAA, strb 4'b0011.
  - Push 0x01, 0x02, then push 0x03 with flush in the same cycle. Required on pop: 0x00030201, strb 4'b0111.
  - Flush with pend_bytes = 0. Required: count unchanged.
- Full: with DEPTH = 4, push 16 bytes. Required: full = 1. A 17th push (0xEE) is dropped and pend_bytes stays 0. Pop one word. Required: full = 0 next cycle; the next 4 pushes are accepted and wrap wr_ptr.
- Simultaneous: with count = 2 and byte_idx = 3, push a byte and pop in the same cycle. Required: count stays 2, and the word order across the wrap is preserved on subsequent pops.
- Reset mid-operation: with 2 words stored and pend_bytes = 3, assert reset. Required: all state cleared. Then push 0x5A, 0x6B, 0x7C, 0x8D. Required on pop: 0x8D7C6B5A, with no residue from before the reset.

Source files
------------

// File: rtl/ofmap_pack_fifo.sv
// Byte-to-word packing FIFO: gathers 8-bit PE results into little-endian 32-bit
// words (with byte strobes) and buffers up to DEPTH words for GLB write-back.
module ofmap_pack_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_en,
  input  logic [7:0]  push_data,
  input  logic        flush,
  output logic        full,
  output logic [1:0]  pend_bytes,
  input  logic        pop_en,
  output logic [31:0] pop_data,
  output logic [3:0]  pop_strb,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [23:0]   pack_r;
  logic [1:0]    byte_idx_r;
  logic [31:0]   mem_r [0:DEPTH-1];
  logic [3:0]    strb_mem_r [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [31:0]   pop_data_r;
  logic [3:0]    pop_strb_r;

  logic        full_s;
  logic        empty_s;
  logic        push_ok_s;
  logic        flush_ok_s;
  logic        pop_ok_s;
  logic        commit_s;
  logic [2:0]  n_s;
  logic [31:0] lanes_s;
  logic [31:0] word_s;
  logic [3:0]  wstrb_s;

  assign full_s     = (count_r == CNT_MAX);
  assign empty_s    = (count_r == {(AW+1){1'b0}});
  assign push_ok_s  = push_en && !full_s;
  assign flush_ok_s = flush && !full_s;
  assign pop_ok_s   = pop_en && !empty_s;
  assign n_s        = {1'b0, byte_idx_r} + {2'b00, push_ok_s};
  assign commit_s   = (push_ok_s && (byte_idx_r == 2'd3)) ||
                      (flush_ok_s && (n_s != 3'd0));
  assign lanes_s    = {8'h00, pack_r};

  assign full       = full_s;
  assign empty      = empty_s;
  assign pend_bytes = byte_idx_r;
  assign pop_data   = pop_data_r;
  assign pop_strb   = pop_strb_r;

  // Build the word to commit: held lanes, then the same-cycle byte, then zero fill.
  always_comb begin
    word_s  = 32'h0000_0000;
    wstrb_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(byte_idx_r)) begin
        word_s[8*i +: 8] = lanes_s[8*i +: 8];
      end else if ((i == int'(byte_idx_r)) && push_ok_s) begin
        word_s[8*i +: 8] = push_data;
      end else begin
        word_s[8*i +: 8] = 8'h00;
      end
      wstrb_s[i] = (i < int'(n_s));
    end
  end

  // Pack register and lane index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_r     <= 24'h000000;
      byte_idx_r <= 2'd0;
    end else if (commit_s) begin
      byte_idx_r <= 2'd0;
    end else if (push_ok_s) begin
      byte_idx_r <= byte_idx_r + 2'd1;
      case (byte_idx_r)
        2'd0:    pack_r[7:0]   <= push_data;
        2'd1:    pack_r[15:8]  <= push_data;
        2'd2:    pack_r[23:16] <= push_data;
        default: pack_r        <= pack_r;
      endcase
    end
  end

  // Word storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[wr_ptr_r]      <= word_s;
      strb_mem_r[wr_ptr_r] <= wstrb_s;
    end
  end

  // Pointers, occupancy and the registered pop port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      pop_data_r <= 32'h0000_0000;
      pop_strb_r <= 4'b0000;
    end else begin
      if (commit_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        pop_data_r <= mem_r[rd_ptr_r];
        pop_strb_r <= strb_mem_r[rd_ptr_r];
      end
      case ({commit_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_pack_fifo.sv
// Bench for ofmap_pack_fifo: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_ofmap_pack_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        push_en;
  logic [7:0]  push_data;
  logic        flush;
  logic        full;
  logic [1:0]  pend_bytes;
  logic        pop_en;
  logic [31:0] pop_data;
  logic [3:0]  pop_strb;
  logic        empty;

  int n_checks = 0;
  int n_fails  = 0;

  ofmap_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push_en(push_en), .push_data(push_data),
    .flush(flush), .full(full), .pend_bytes(pend_bytes), .pop_en(pop_en),
    .pop_data(pop_data), .pop_strb(pop_strb), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending bytes and stored {strb, data} words as queues.
  logic [7:0]  pend_q[$];
  logic [35:0] word_q[$];
  logic [31:0] m_data;
  logic [3:0]  m_strb;

  task automatic model_reset();
    pend_q.delete();
    word_q.delete();
    m_data = 32'h0;
    m_strb = 4'h0;
  endtask

  task automatic model_step(input logic pe, input logic [7:0] pd, input logic fl, input logic pp);
    logic        is_full;
    logic [35:0] w;
    logic [31:0] d;
    int          n;
    is_full = (word_q.size() == DEPTH);
    if (pp && word_q.size() > 0) begin
      w = word_q.pop_front();
      m_data = w[31:0];
      m_strb = w[35:32];
    end
    if (pe && !is_full) pend_q.push_back(pd);
    if (pend_q.size() == 4 || (fl && !is_full && pend_q.size() > 0)) begin
      n = pend_q.size();
      d = 32'h0;
      for (int i = 0; i < n; i++) d = d | (32'(pend_q[i]) << (8 * i));
      word_q.push_back({4'((1 << n) - 1), d});
      pend_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pend_bytes"}, 32'(pend_bytes), 32'(pend_q.size()));
    chk({tag, " empty"}, 32'(empty), 32'(word_q.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(word_q.size() == DEPTH));
    chk({tag, " pop_data"}, pop_data, m_data);
    chk({tag, " pop_strb"}, 32'(pop_strb), 32'(m_strb));
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic pe, input logic [7:0] pd, input logic fl, input logic pp);
    push_en = pe; push_data = pd; flush = fl; pop_en = pp;
    model_step(pe, pd, fl, pp);
    @(posedge clk);
    #1;
    push_en = 1'b0; flush = 1'b0; pop_en = 1'b0;
  endtask

  typedef struct {
    logic        pe;
    logic [7:0]  pd;
    logic        fl;
    logic        pp;
    logic [1:0]  e_pend;
    logic        e_empty;
    logic        e_full;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pe, input logic [7:0] pd, input logic fl, input logic pp,
                     input logic [1:0] ep, input logic ee, input logic ef,
                     input logic [31:0] ed, input logic [3:0] es);
    vec_t v;
    v.pe = pe; v.pd = pd; v.fl = fl; v.pp = pp;
    v.e_pend = ep; v.e_empty = ee; v.e_full = ef; v.e_data = ed; v.e_strb = es;
    vecs.push_back(v);
  endtask

  initial begin
    push_en = 1'b0; push_data = 8'h00; flush = 1'b0; pop_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset pop_data", pop_data, 32'h0);
    chk("reset pop_strb", 32'(pop_strb), 32'h0);
    chk("reset empty", 32'(empty), 32'h1);
    chk("reset full", 32'(full), 32'h0);
    chk("reset pend_bytes", 32'(pend_bytes), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //   pe    pd    fl    pp    pend  emp   full  data          strb
    add(1'b1, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h00000000, 4'h0);
    add(1'b1, 8'h22, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h00000000, 4'h0);
    add(1'b1, 8'h33, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 32'h00000000, 4'h0);
    add(1'b1, 8'h44, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00000000, 4'h0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h44332211, 4'hF);
    add(1'b1, 8'hAA, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h44332211, 4'hF);
    add(1'b1, 8'hBB, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h44332211, 4'hF);
    add(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h44332211, 4'hF);
    add(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0000BBAA, 4'h3);
    add(1'b1, 8'h01, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h0000BBAA, 4'h3);
    add(1'b1, 8'h02, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h0000BBAA, 4'h3);
    add(1'b1, 8'h03, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0000BBAA, 4'h3);
    add(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h00030201, 4'h7);
    add(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h00030201, 4'h7);
    add(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h00030201, 4'h7);

    for (int k = 0; k < vecs.size(); k++) begin
      cycle(vecs[k].pe, vecs[k].pd, vecs[k].fl, vecs[k].pp);
      chk($sformatf("vec%0d pend_bytes", k), 32'(pend_bytes), 32'(vecs[k].e_pend));
      chk($sformatf("vec%0d empty", k), 32'(empty), 32'(vecs[k].e_empty));
      chk($sformatf("vec%0d full", k), 32'(full), 32'(vecs[k].e_full));
      chk($sformatf("vec%0d pop_data", k), pop_data, vecs[k].e_data);
      chk($sformatf("vec%0d pop_strb", k), 32'(pop_strb), 32'(vecs[k].e_strb));
    end

    // Fill to full, drop a 17th byte, free one slot, refill across the wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("fill full", 32'(full), 32'h1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("drop pend_bytes", 32'(pend_bytes), 32'h0);
    chk("drop full", 32'(full), 32'h1);
    cycle(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("full pop data", pop_data, 32'h13121110);
    chk("full pop drops push", 32'(pend_bytes), 32'h0);
    chk("full clears", 32'(full), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("refill full", 32'(full), 32'h1);
    check_model("refill");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check_model("drain");
    end
    chk("last drained word", pop_data, 32'h53525150);

    // Count 2 with 3 pending bytes: commit and pop together.
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h6B, 1'b0, 1'b1);
    chk("simul pop", pop_data, 32'h63626160);
    chk("simul pend", 32'(pend_bytes), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    chk("simul count 3", 32'(full), 32'h0);
    cycle(1'b1, 8'h74, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h75 + i), 1'b0, 1'b0);
    chk("simul count 4", 32'(full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check_model("simul drain");
    end
    chk("simul last", pop_data, 32'h77767574);

    // Reset with 2 words stored and 3 bytes pending.
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst empty", 32'(empty), 32'h1);
    chk("midrst full", 32'(full), 32'h0);
    chk("midrst pend", 32'(pend_bytes), 32'h0);
    chk("midrst pop_data", pop_data, 32'h0);
    chk("midrst pop_strb", 32'(pop_strb), 32'h0);
    #1 rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h6B, 1'b0, 1'b0);
    cycle(1'b1, 8'h7C, 1'b0, 1'b0);
    cycle(1'b1, 8'h8D, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("post-reset word", pop_data, 32'h8D7C6B5A);
    chk("post-reset strb", 32'(pop_strb), 32'hF);
    chk("post-reset empty", 32'(empty), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 3));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
